// File: rtl/pgm_wr_pkg.sv
// Shared encodings for the template-packet writer: FSM states, packet header
// codes, config opcodes and config register addresses.
package pgm_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BYPASS = 3'd1,
    ST_STORE  = 3'd2,
    ST_READY  = 3'd3,
    ST_SENT   = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  localparam logic [2:0] OP_WR = 3'b010;
  localparam logic [2:0] OP_RD = 3'b001;

  localparam logic [3:0] RD_RESP = 4'b1011;

  localparam logic [31:0] REG_SOFT_RST = 32'h0;
  localparam logic [31:0] REG_START    = 32'h1;
  localparam logic [31:0] REG_DUR      = 32'h2;
  localparam logic [31:0] REG_WORD_CNT = 32'h3;
  localparam logic [31:0] REG_TRUNC    = 32'h4;
  localparam logic [31:0] REG_STATE    = 32'h5;

  localparam logic [7:0] LAST_ADDR = 8'd127;

endpackage

// File: rtl/pgm_wr_cfg.sv
// Config register file for pgm_wr: decodes LMID config packets on the cin
// path, holds dur_reg, emits soft_rst/start pulses and answers reads on cout.
module pgm_wr_cfg
  import pgm_wr_pkg::*;
#(
  parameter logic [7:0] LMID = 8'd61
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] cin_wr_data,
  input  logic         cin_wr_data_wr,
  input  logic         cin_wr_ready,
  output logic         cout_wr_ready,
  output logic [133:0] cout_wr_data,
  output logic         cout_wr_data_wr,
  input  logic [7:0]   word_cnt,
  input  logic [31:0]  trunc_cnt,
  input  logic [2:0]   state,
  output logic         soft_rst,
  output logic         start,
  output logic [31:0]  dur_reg
);

  logic        is_cfg;
  logic [2:0]  op;
  logic [31:0] addr;
  logic        wr_hit;
  logic [31:0] rd_val;
  logic [133:0] resp;

  assign cout_wr_ready = cin_wr_ready;

  always_comb begin
    op     = cin_wr_data[126:124];
    addr   = cin_wr_data[95:64];
    is_cfg = cin_wr_data_wr && cin_wr_ready &&
             (cin_wr_data[133:132] == HDR_HEAD) &&
             (cin_wr_data[103:96] == LMID);
    wr_hit = is_cfg && (op == OP_WR);
    case (addr)
      REG_SOFT_RST: rd_val = '0;
      REG_START:    rd_val = '0;
      REG_DUR:      rd_val = dur_reg;
      REG_WORD_CNT: rd_val = {24'b0, word_cnt};
      REG_TRUNC:    rd_val = trunc_cnt;
      REG_STATE:    rd_val = {29'b0, state};
      default:      rd_val = '1;
    endcase
    resp = cin_wr_data;
    if (is_cfg && (op == OP_RD)) begin
      resp[127:124] = RD_RESP;
      resp[31:0]    = rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_wr_data    <= '0;
      cout_wr_data_wr <= 1'b0;
      soft_rst        <= 1'b0;
      start           <= 1'b0;
      dur_reg         <= '1;
    end else begin
      cout_wr_data_wr <= cin_wr_data_wr;
      if (cin_wr_data_wr) cout_wr_data <= resp;
      soft_rst <= wr_hit && (addr == REG_SOFT_RST) && cin_wr_data[0];
      start    <= wr_hit && (addr == REG_START) && cin_wr_data[0];
      if (wr_hit && (addr == REG_DUR)) dur_reg <= cin_wr_data[31:0];
    end
  end

endmodule

// File: rtl/pgm_wr.sv
// Template-packet writer: stores LMID-steered packets into the template RAM,
// bypasses all other traffic to pgm_rd, and sequences the timed send window.
module pgm_wr
  import pgm_wr_pkg::*;
#(
  parameter logic [7:0] LMID = 8'd61,
  parameter logic [7:0] NMID = 8'd62
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] in_wr_phv,
  input  logic          in_wr_phv_wr,
  output logic          out_wr_phv_alf,
  input  logic [133:0]  in_wr_data,
  input  logic          in_wr_data_wr,
  input  logic          in_wr_valid,
  input  logic          in_wr_valid_wr,
  output logic          out_wr_alf,
  output logic [1023:0] out_wr_phv,
  output logic          out_wr_phv_wr,
  input  logic          in_wr_phv_alf,
  output logic [133:0]  out_wr_data,
  output logic          out_wr_data_wr,
  output logic          out_wr_valid,
  output logic          out_wr_valid_wr,
  input  logic          in_wr_alf,
  output logic          pgm_bypass_flag,
  output logic          pgm_sent_start_flag,
  output logic          pgm_sent_finish_flag,
  output logic          wr2ram_wr,
  output logic [6:0]    wr2ram_addr,
  output logic [143:0]  wr2ram_wdata,
  input  logic [133:0]  cin_wr_data,
  input  logic          cin_wr_data_wr,
  output logic          cout_wr_ready,
  output logic [133:0]  cout_wr_data,
  output logic          cout_wr_data_wr,
  input  logic          cin_wr_ready
);

  state_t      state;
  logic [7:0]  word_cnt;
  logic [31:0] trunc_cnt;
  logic [31:0] dur_cnt;
  logic [31:0] dur_reg;
  logic        soft_rst;
  logic        start;
  logic        trunc;
  logic        drop;
  logic        ret_ready;
  logic        is_head;
  logic        is_tail;
  logic        is_lmid;
  logic        fwd;
  logic        fwd_valid;
  logic        fwd_phv;
  logic        ovf;

  assign out_wr_phv_alf = in_wr_phv_alf;
  assign out_wr_alf     = in_wr_alf;

  pgm_wr_cfg #(.LMID(LMID)) u_cfg (
    .clk             (clk),
    .rst             (rst),
    .cin_wr_data     (cin_wr_data),
    .cin_wr_data_wr  (cin_wr_data_wr),
    .cin_wr_ready    (cin_wr_ready),
    .cout_wr_ready   (cout_wr_ready),
    .cout_wr_data    (cout_wr_data),
    .cout_wr_data_wr (cout_wr_data_wr),
    .word_cnt        (word_cnt),
    .trunc_cnt       (trunc_cnt),
    .state           (state),
    .soft_rst        (soft_rst),
    .start           (start),
    .dur_reg         (dur_reg)
  );

  always_comb begin
    is_head = in_wr_data_wr && (in_wr_data[133:132] == HDR_HEAD);
    is_tail = in_wr_data_wr && (in_wr_data[133:132] == HDR_TAIL);
    is_lmid = (in_wr_data[111:104] == LMID);
    // A new non-LMID head is forwarded from IDLE, or from READY unless start wins.
    fwd = in_wr_data_wr &&
          ((state == ST_BYPASS) ||
           (is_head && !is_lmid &&
            ((state == ST_IDLE) || ((state == ST_READY) && !drop && !start))));
    fwd_valid = in_wr_valid_wr && ((state == ST_BYPASS) || fwd);
    fwd_phv   = in_wr_phv_wr && pgm_bypass_flag;
    ovf = (state == ST_STORE) && in_wr_data_wr && !trunc &&
          (word_cnt == LAST_ADDR) && !is_tail;
  end

  // trunc_cnt survives soft reset, so it only answers to the hard reset.
  always_ff @(posedge clk) begin
    if (rst) trunc_cnt <= '0;
    else if (ovf) trunc_cnt <= trunc_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      state                <= ST_IDLE;
      word_cnt             <= '0;
      dur_cnt              <= '0;
      trunc                <= 1'b0;
      drop                 <= 1'b0;
      ret_ready            <= 1'b0;
      out_wr_data          <= '0;
      out_wr_data_wr       <= 1'b0;
      out_wr_valid         <= 1'b0;
      out_wr_valid_wr      <= 1'b0;
      out_wr_phv           <= '0;
      out_wr_phv_wr        <= 1'b0;
      pgm_bypass_flag      <= 1'b1;
      pgm_sent_start_flag  <= 1'b0;
      pgm_sent_finish_flag <= 1'b0;
      wr2ram_wr            <= 1'b0;
      wr2ram_addr          <= '0;
      wr2ram_wdata         <= '0;
    end else begin
      out_wr_data_wr  <= fwd;
      out_wr_valid_wr <= fwd_valid;
      out_wr_phv_wr   <= fwd_phv;
      if (fwd) out_wr_data <= in_wr_data;
      if (fwd_valid) out_wr_valid <= in_wr_valid;
      if (fwd_phv) out_wr_phv <= in_wr_phv;
      wr2ram_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_head) begin
            if (is_lmid) begin
              state           <= ST_STORE;
              pgm_bypass_flag <= 1'b0;
              wr2ram_wr       <= 1'b1;
              wr2ram_addr     <= '0;
              wr2ram_wdata    <= {10'b0, in_wr_data};
              word_cnt        <= 8'd1;
              trunc           <= 1'b0;
            end else begin
              state     <= ST_BYPASS;
              ret_ready <= 1'b0;
            end
          end
        end
        ST_BYPASS: begin
          if (is_tail) state <= ret_ready ? ST_READY : ST_IDLE;
        end
        ST_STORE: begin
          if (in_wr_data_wr) begin
            if (!trunc) begin
              wr2ram_wr   <= 1'b1;
              wr2ram_addr <= word_cnt[6:0];
              word_cnt    <= word_cnt + 8'd1;
              if (word_cnt == LAST_ADDR)
                wr2ram_wdata <= {10'b0, HDR_TAIL, in_wr_data[131:0]};
              else
                wr2ram_wdata <= {10'b0, in_wr_data};
            end
            if (is_tail) begin
              state           <= ST_READY;
              pgm_bypass_flag <= 1'b1;
              trunc           <= 1'b0;
            end else if (ovf) begin
              trunc <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (start) begin
            state               <= ST_SENT;
            pgm_bypass_flag     <= 1'b0;
            pgm_sent_start_flag <= 1'b1;
            dur_cnt             <= '0;
            drop                <= 1'b0;
          end else if (drop) begin
            if (is_tail) drop <= 1'b0;
          end else if (is_head) begin
            if (is_lmid) begin
              drop <= 1'b1;
            end else begin
              state     <= ST_BYPASS;
              ret_ready <= 1'b1;
            end
          end
        end
        ST_SENT: begin
          if (dur_cnt == dur_reg) begin
            state                <= ST_FIN;
            pgm_sent_finish_flag <= 1'b1;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end
        ST_FIN: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_wr.sv
// Scoreboard bench for pgm_wr: packet-level reference model feeds expectation
// queues, independent monitors pop and compare every DUT output event.
module tb_pgm_wr;

  localparam logic [7:0] MID = 8'd61;
  localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] in_wr_phv;
  logic          in_wr_phv_wr;
  logic          out_wr_phv_alf;
  logic [133:0]  in_wr_data;
  logic          in_wr_data_wr;
  logic          in_wr_valid;
  logic          in_wr_valid_wr;
  logic          out_wr_alf;
  logic [1023:0] out_wr_phv;
  logic          out_wr_phv_wr;
  logic          in_wr_phv_alf;
  logic [133:0]  out_wr_data;
  logic          out_wr_data_wr;
  logic          out_wr_valid;
  logic          out_wr_valid_wr;
  logic          in_wr_alf;
  logic          pgm_bypass_flag;
  logic          pgm_sent_start_flag;
  logic          pgm_sent_finish_flag;
  logic          wr2ram_wr;
  logic [6:0]    wr2ram_addr;
  logic [143:0]  wr2ram_wdata;
  logic [133:0]  cin_wr_data;
  logic          cin_wr_data_wr;
  logic          cout_wr_ready;
  logic [133:0]  cout_wr_data;
  logic          cout_wr_data_wr;
  logic          cin_wr_ready;

  pgm_wr #(.LMID(8'd61), .NMID(8'd62)) dut (
    .clk(clk), .rst(rst),
    .in_wr_phv(in_wr_phv), .in_wr_phv_wr(in_wr_phv_wr), .out_wr_phv_alf(out_wr_phv_alf),
    .in_wr_data(in_wr_data), .in_wr_data_wr(in_wr_data_wr), .in_wr_valid(in_wr_valid),
    .in_wr_valid_wr(in_wr_valid_wr), .out_wr_alf(out_wr_alf),
    .out_wr_phv(out_wr_phv), .out_wr_phv_wr(out_wr_phv_wr), .in_wr_phv_alf(in_wr_phv_alf),
    .out_wr_data(out_wr_data), .out_wr_data_wr(out_wr_data_wr), .out_wr_valid(out_wr_valid),
    .out_wr_valid_wr(out_wr_valid_wr), .in_wr_alf(in_wr_alf),
    .pgm_bypass_flag(pgm_bypass_flag), .pgm_sent_start_flag(pgm_sent_start_flag),
    .pgm_sent_finish_flag(pgm_sent_finish_flag),
    .wr2ram_wr(wr2ram_wr), .wr2ram_addr(wr2ram_addr), .wr2ram_wdata(wr2ram_wdata),
    .cin_wr_data(cin_wr_data), .cin_wr_data_wr(cin_wr_data_wr), .cout_wr_ready(cout_wr_ready),
    .cout_wr_data(cout_wr_data), .cout_wr_data_wr(cout_wr_data_wr), .cin_wr_ready(cin_wr_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic [133:0] d; logic v; } out_exp_t;
  typedef struct { int t; logic [6:0] a; logic [143:0] d; } ram_exp_t;
  typedef struct { int t; logic [1023:0] p; } phv_exp_t;
  typedef struct { int t; logic [133:0] d; } cout_exp_t;

  out_exp_t  out_q[$];
  ram_exp_t  ram_q[$];
  phv_exp_t  phv_q[$];
  cout_exp_t cout_q[$];

  int checks = 0;
  int failures = 0;

  int m_mode = M_IDLE;
  int m_word_cnt = 0;
  int m_trunc = 0;
  logic [31:0] m_dur = 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: output event with nothing expected at cycle %0d", name, cyc);
  endtask

  // Monitors
  always @(negedge clk) begin : mon_out
    out_exp_t e;
    if (out_wr_data_wr) begin
      if (out_q.size() == 0) unexpected("out_data");
      else begin
        e = out_q.pop_front();
        chk("out_data", out_wr_data, e.d);
        chk("out_time", cyc, e.t);
        chk("out_valid_wr", out_wr_valid_wr, e.v);
        if (e.v) chk("out_valid", out_wr_valid, 1'b1);
      end
    end else if (out_wr_valid_wr) unexpected("out_valid_wr");
  end

  always @(negedge clk) begin : mon_ram
    ram_exp_t e;
    if (wr2ram_wr) begin
      if (ram_q.size() == 0) unexpected("ram_wr");
      else begin
        e = ram_q.pop_front();
        chk("ram_addr", wr2ram_addr, e.a);
        chk("ram_data", wr2ram_wdata, e.d);
        chk("ram_time", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin : mon_phv
    phv_exp_t e;
    if (out_wr_phv_wr) begin
      if (phv_q.size() == 0) unexpected("phv_wr");
      else begin
        e = phv_q.pop_front();
        checks++;
        if (out_wr_phv !== e.p) begin
          failures++;
          $display("FAIL phv_data: got low %h expected low %h", out_wr_phv[63:0], e.p[63:0]);
        end
        chk("phv_time", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin : mon_cout
    cout_exp_t e;
    if (cout_wr_data_wr) begin
      if (cout_q.size() == 0) unexpected("cout");
      else begin
        e = cout_q.pop_front();
        chk("cout_data", cout_wr_data, e.d);
        chk("cout_time", cyc, e.t);
      end
    end
  end

  function automatic logic [133:0] rand_word(input logic [1:0] hdr, input logic [7:0] mid);
    logic [159:0] r;
    logic [133:0] w;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w = r[133:0];
    w[133:132] = hdr;
    w[111:104] = mid;
    return w;
  endfunction

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] p;
    for (int k = 0; k < 32; k++) p[k*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic logic [133:0] cfg_word(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] wd);
    logic [133:0] w;
    w = rand_word(2'b01, 8'h00);
    w[126:124] = op;
    w[103:96]  = MID;
    w[95:64]   = addr;
    w[31:0]    = wd;
    return w;
  endfunction

  // Drives one config word this cycle and queues its cout image.
  task automatic put_cfg(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rexp);
    logic [133:0] w, e;
    w = cfg_word(op, addr, wd);
    e = w;
    if (op == 3'b001) begin
      e[127:124] = 4'b1011;
      e[31:0]    = rexp;
    end
    cin_wr_data    = w;
    cin_wr_data_wr = 1'b1;
    cout_q.push_back('{cyc + 1, e});
  endtask

  task automatic cfg_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rexp);
    @(posedge clk); #1;
    put_cfg(op, addr, wd, rexp);
    @(posedge clk); #1;
    cin_wr_data_wr = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] addr, input logic [31:0] rexp);
    cfg_op(3'b001, addr, $urandom, rexp);
    repeat (2) @(posedge clk);
  endtask

  task automatic soft_reset();
    cfg_op(3'b010, 32'h0, 32'h1, 32'h0);
    repeat (3) @(posedge clk);
    m_mode = M_IDLE;
    m_word_cnt = 0;
  endtask

  task automatic do_start();
    cfg_op(3'b010, 32'h1, 32'h1, 32'h0);
    if (m_mode == M_READY) m_mode = M_RUN;
  endtask

  task automatic send_pkt(input logic [7:0] mid, input int n, input bit with_phv,
                          input bit start_at_tail);
    bit byp, tmpl;
    logic [133:0] w, fw;
    logic [1023:0] p;
    logic [1:0] hdr;
    byp  = (mid != MID) && (m_mode != M_RUN);
    tmpl = (mid == MID) && (m_mode == M_IDLE);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      hdr = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b11;
      w = rand_word(hdr, mid);
      p = rand_phv();
      in_wr_data     = w;
      in_wr_data_wr  = 1'b1;
      in_wr_valid_wr = (i == n - 1);
      in_wr_valid    = (i == n - 1);
      in_wr_phv      = p;
      in_wr_phv_wr   = with_phv && (i == 0);
      if (byp) out_q.push_back('{cyc + 1, w, (i == n - 1)});
      if (byp && with_phv && i == 0) phv_q.push_back('{cyc + 1, p});
      if (tmpl && i < 128) begin
        fw = w;
        if (i == 127) fw[133:132] = 2'b10;
        ram_q.push_back('{cyc + 1, 7'(i), {10'b0, fw}});
      end
      if (start_at_tail && i == n - 1) put_cfg(3'b010, 32'h1, 32'h1, 32'h0);
    end
    @(posedge clk); #1;
    in_wr_data_wr  = 1'b0;
    in_wr_valid_wr = 1'b0;
    in_wr_phv_wr   = 1'b0;
    cin_wr_data_wr = 1'b0;
    if (tmpl) begin
      m_word_cnt = (n > 128) ? 128 : n;
      if (n > 128) m_trunc++;
      m_mode = M_READY;
    end
    if (start_at_tail && m_mode == M_READY) m_mode = M_RUN;
  endtask

  function automatic logic [7:0] rand_mid();
    logic [7:0] m;
    m = 8'($urandom_range(0, 255));
    if (m == MID) m = 8'h10;
    return m;
  endfunction

  task automatic check_flags(input string tag, input logic b, input logic s, input logic f);
    @(negedge clk);
    chk({tag, "_bypass"}, pgm_bypass_flag, b);
    chk({tag, "_start"}, pgm_sent_start_flag, s);
    chk({tag, "_finish"}, pgm_sent_finish_flag, f);
  endtask

  initial begin : stim
    int cnt;
    bit done;
    rst = 1'b1;
    in_wr_phv = '0; in_wr_phv_wr = 1'b0; in_wr_phv_alf = 1'b0;
    in_wr_data = '0; in_wr_data_wr = 1'b0; in_wr_valid = 1'b0; in_wr_valid_wr = 1'b0;
    in_wr_alf = 1'b0; cin_wr_data = '0; cin_wr_data_wr = 1'b0; cin_wr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_wr", out_wr_data_wr, 1'b0);
    chk("rst_out_data", out_wr_data, 134'b0);
    chk("rst_ram_wr", wr2ram_wr, 1'b0);
    chk("rst_ram_addr", wr2ram_addr, 7'b0);
    chk("rst_cout_wr", cout_wr_data_wr, 1'b0);
    check_flags("rst", 1'b1, 1'b0, 1'b0);
    in_wr_alf = 1'b1; in_wr_phv_alf = 1'b1;
    #1;
    chk("alf", out_wr_alf, 1'b1);
    chk("phv_alf", out_wr_phv_alf, 1'b1);
    in_wr_alf = 1'b0; in_wr_phv_alf = 1'b0;
    cfg_read(32'h3, 32'd0);
    cfg_read(32'h2, 32'hFFFF_FFFF);

    // Bypass traffic from IDLE
    send_pkt(8'h10, 4, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) send_pkt(rand_mid(), $urandom_range(2, 6), 1'($urandom), 1'b0);
    check_flags("idle", 1'b1, 1'b0, 1'b0);

    // Overflowing template
    send_pkt(MID, 130, 1'b0, 1'b0);
    check_flags("ovf", 1'b1, 1'b0, 1'b0);
    cfg_read(32'h4, 32'(m_trunc));
    cfg_read(32'h3, 32'(m_word_cnt));

    soft_reset();
    check_flags("srst1", 1'b1, 1'b0, 1'b0);
    cfg_read(32'h3, 32'd0);
    cfg_read(32'h4, 32'(m_trunc));

    // Regular template, then READY behaviour
    send_pkt(MID, 5, 1'b0, 1'b0);
    cfg_read(32'h3, 32'd5);
    cfg_read(32'h9, 32'hFFFF_FFFF);
    send_pkt(MID, 3, 1'b0, 1'b0);
    send_pkt(rand_mid(), 3, 1'b1, 1'b0);
    send_pkt(MID, 4, 1'b0, 1'b0);
    cfg_read(32'h3, 32'd5);
    check_flags("ready", 1'b1, 1'b0, 1'b0);

    // Timed send window
    cfg_op(3'b010, 32'h2, 32'd10, 32'h0);
    m_dur = 32'd10;
    cfg_read(32'h2, m_dur);
    do_start();
    cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (pgm_sent_finish_flag) done = 1'b1;
      else if (pgm_sent_start_flag) cnt++;
    end
    chk("sent_cycles", cnt, 32'(m_dur + 1));
    chk("fin_reached", done, 1'b1);
    send_pkt(rand_mid(), 3, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    check_flags("fin", 1'b0, 1'b1, 1'b1);

    // Start coinciding with template tail, then soft reset mid-SENT
    soft_reset();
    cfg_op(3'b010, 32'h2, 32'd1000, 32'h0);
    m_dur = 32'd1000;
    send_pkt(MID, 2, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    check_flags("sent", 1'b0, 1'b1, 1'b0);
    soft_reset();
    check_flags("srst2", 1'b1, 1'b0, 1'b0);
    cfg_read(32'h3, 32'd0);
    cfg_read(32'h2, m_dur);
    cfg_read(32'h4, 32'(m_trunc));

    // Hard reset in the middle of a template
    for (int i = 0; i < 3; i++) begin
      logic [133:0] w;
      @(posedge clk); #1;
      w = rand_word((i == 0) ? 2'b01 : 2'b11, MID);
      in_wr_data = w; in_wr_data_wr = 1'b1;
      ram_q.push_back('{cyc + 1, 7'(i), {10'b0, w}});
    end
    @(posedge clk); #1;
    in_wr_data_wr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_mode = M_IDLE; m_word_cnt = 0; m_trunc = 0; m_dur = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_wr_data = rand_word((i == 2) ? 2'b10 : 2'b11, MID);
      in_wr_data_wr = 1'b1;
    end
    @(posedge clk); #1;
    in_wr_data_wr = 1'b0;
    cfg_read(32'h3, 32'd0);
    cfg_read(32'h2, 32'hFFFF_FFFF);
    send_pkt(rand_mid(), 3, 1'b1, 1'b0);

    repeat (6) @(posedge clk);
    chk("out_q_drained", out_q.size(), 0);
    chk("ram_q_drained", ram_q.size(), 0);
    chk("phv_q_drained", phv_q.size(), 0);
    chk("cout_q_drained", cout_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pgm_wr.md
PGM_WR -- requirements
Module: pgm_wr

Interface
REQ-001 Parameter LMID, default 8'd61, own module ID for config packets and template-packet steering.
REQ-002 Parameter NMID, default 8'd62, next module ID (pgm_rd); carried for completeness, no logic uses it.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_wr_phv / in_wr_phv_wr  in  1024/1  PHV from upstream; out_wr_phv_alf out 1 = in_wr_phv_alf.
REQ-006 in_wr_data / in_wr_data_wr / in_wr_valid / in_wr_valid_wr  in  134/1/1/1  packet words; [133:132] 01 head, 11 middle, 10 tail; out_wr_alf out 1 = in_wr_alf.
REQ-007 out_wr_phv / out_wr_phv_wr / out_wr_data / out_wr_data_wr / out_wr_valid / out_wr_valid_wr  out  1024/1/134/1/1/1  registered pass-through to pgm_rd; in_wr_phv_alf, in_wr_alf in 1 from pgm_rd.
REQ-008 pgm_bypass_flag / pgm_sent_start_flag / pgm_sent_finish_flag  out  1/1/1  control levels to pgm_rd.
REQ-009 wr2ram_wr / wr2ram_addr / wr2ram_wdata  out  1/7/144  template RAM write port; wdata = {10'b0, word}.
REQ-010 cin_wr_data / cin_wr_data_wr  in  134/1; cout_wr_ready out 1 = cin_wr_ready; cout_wr_data / cout_wr_data_wr out 134/1; cin_wr_ready in 1.

Function
REQ-011 States IDLE, BYPASS, STORE, READY, SENT, FIN.
REQ-012 IDLE: head word (data_wr=1, [133:132]=01) with [111:104]==LMID -> STORE, head written to RAM addr 0; other head -> BYPASS, forwarded.
REQ-013 BYPASS: every in word forwarded next cycle (all data/phv/valid signals registered, latency 1); tail -> IDLE.
REQ-014 STORE: each word written at incrementing address, none forwarded; tail -> READY with word_cnt = words stored.
REQ-015 STORE overflow: 128th word (addr 127) written with [133:132] forced 10; remaining words dropped until tail; trunc_cnt +1; then READY.
REQ-016 READY: further LMID templates dropped (not stored); other packets bypass and return to READY; software start write -> SENT.
REQ-017 SENT: pgm_sent_start_flag=1; dur_cnt +1 per cycle; dur_cnt == dur_reg -> FIN; input packets dropped.
REQ-018 FIN: pgm_sent_finish_flag=1, start_flag held 1; leaves only on soft reset.
REQ-019 pgm_bypass_flag = 1 in IDLE, BYPASS, READY; 0 otherwise.
REQ-020 Config first word (cin_wr_data_wr=1, [133:132]=01, cin_wr_ready=1), [103:96]==LMID: [126:124]=010 write, 001 read, address [95:64].
REQ-021 Registers: 0x0 soft_rst (W, bit0); 0x1 start (W, bit0 pulse); 0x2 dur_reg (RW, 32b, reset FFFFFFFF); 0x3 word_cnt (RO); 0x4 trunc_cnt (RO); 0x5 state (RO).
REQ-022 Read response: [127:124]=4'b1011, [31:0]=value, unknown address -> FFFFFFFF, other bits unchanged; writes and non-LMID words forwarded unchanged; cout latency 1.
REQ-023 Simultaneous start write and template tail: tail completes READY first; start takes effect next cycle only if in READY.
REQ-024 soft_rst=1 acts as rst for the datapath and FSM one cycle later; config registers dur_reg and trunc_cnt are retained.

Reset
REQ-025 rst: all outputs 0 except pgm_bypass_flag=1; state IDLE; counters 0; dur_reg FFFFFFFF.
REQ-026 rst mid-STORE abandons the template: word_cnt=0; no further RAM writes.

Structure
REQ-027 Shared package: state encodings, config addresses, header codes 01/11/10, op codes 010/001.
REQ-028 One sub-module pgm_wr_cfg (config register file and cout path); FSM and datapath in top.

Verification
REQ-029 Bypass 4-word packet with MID 0x10 -> identical words on out_wr_* one cycle later, bypass_flag=1, no RAM writes.
REQ-030 Template 5 words, MID 61 -> RAM addr 0..4 written, word_cnt=5, state READY, nothing forwarded.
REQ-031 Template 130 words -> addr 0..127 written, addr 127 header 10, trunc_cnt=1.
REQ-032 dur_reg=10, start -> start_flag=1 for 11 cycles, then finish_flag=1, FIN held.
REQ-033 Config read 0x3 after 5-word template -> cout [127:124]=1011, [31:0]=5; read 0x9 -> FFFFFFFF.
REQ-034 soft_rst write during SENT -> IDLE, flags 0/0, bypass 1, word_cnt 0, dur_reg retained.
